// File: rtl/sccb_write_master.sv
// sccb_write_master: SCCB 3-phase write master (ID, register address, data) for the OV2640 config path
//
// Parameters:
//   CLK_FREQ  - system clock frequency in Hz
//   SCCB_FREQ - sioc frequency in Hz
//   SID       - 8-bit device write ID, sent MSB first
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   send  - level request, a {rega,value} pair is pending
//   rega  - register address, latched at acceptance
//   value - register data, latched at acceptance
//   taken - one-cycle pulse after the pair is latched
//   busy  - high from acceptance through the bus-free gap
//   nack  - sticky missing-acknowledge flag (only with SCCB_ACK_CHECK_EN)
//   sioc  - SCCB clock, push-pull, idles high
//   siod  - SCCB data, released in don't-care slots
// Optional feature macro: SCCB_ACK_CHECK_EN (samples siod in don't-care slots to drive nack)
module sccb_write_master #(
    parameter int         CLK_FREQ  = 50_000_000,
    parameter int         SCCB_FREQ = 100_000,
    parameter logic [7:0] SID       = 8'h60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] rega,
    input  logic [7:0] value,
    output logic       taken,
    output logic       busy,
    output logic       nack,
    output logic       sioc,
    inout  wire        siod
);
    localparam int QDIV = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int QW   = (QDIV > 2) ? $clog2(QDIV) : 1;

    generate
        if (QDIV < 2) begin : g_qdiv_chk
            $error("sccb_write_master: QDIV must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, BITS, STOP, GAP} state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      quar_q, quar_d;
    logic [1:0]      phase_q, phase_d;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      rega_q, rega_d;
    logic [7:0]      value_q, value_d;
    logic            taken_q, taken_d;
    logic            tick, accept, dc_bit, siod_out;
    logic [7:0]      cur_byte;

    always_comb begin
        tick     = qcnt_q == QW'(QDIV - 1);
        accept   = state_q == IDLE && send;
        dc_bit   = state_q == BITS && bit_q == 4'd0;
        cur_byte = phase_q == 2'd0 ? SID : phase_q == 2'd1 ? rega_q : value_q;
        state_d  = state_q;
        qcnt_d   = tick ? '0 : qcnt_q + 1'b1;
        quar_d   = tick ? quar_q + 2'd1 : quar_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        rega_d   = rega_q;
        value_d  = value_q;
        taken_d  = accept;
        if (state_q == IDLE) begin
            qcnt_d = '0;
            quar_d = '0;
            if (send) begin
                state_d = START;
                rega_d  = rega;
                value_d = value;
            end
        end else if (tick && quar_q == 2'd3) begin
            case (state_q)
                START: begin
                    state_d = BITS;
                    bit_d   = 4'd8;
                    phase_d = 2'd0;
                end
                BITS: begin
                    if (bit_q != 4'd0) begin
                        bit_d = bit_q - 4'd1;
                    end else if (phase_q == 2'd2) begin
                        state_d = STOP;
                    end else begin
                        phase_d = phase_q + 2'd1;
                        bit_d   = 4'd8;
                    end
                end
                STOP:    state_d = GAP;
                GAP:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        // bit_q 8..1 carries data bits 7..0; bit_q 0 is the don't-care slot
        sioc = state_q == START ? quar_q != 2'd3 :
               state_q == BITS  ? quar_q[1] :
               state_q == STOP  ? quar_q != 2'd0 : 1'b1;
        siod_out = state_q == START ? quar_q == 2'd0 :
                   state_q == BITS  ? cur_byte[3'(bit_q - 4'd1)] :
                   state_q == STOP  ? quar_q[1] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            qcnt_q  <= '0;
            quar_q  <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            rega_q  <= '0;
            value_q <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            quar_q  <= quar_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            rega_q  <= rega_d;
            value_q <= value_d;
            taken_q <= taken_d;
        end
    end

    assign siod  = dc_bit ? 1'bz : siod_out;
    assign busy  = state_q != IDLE;
    assign taken = taken_q;

`ifdef SCCB_ACK_CHECK_EN
    logic nack_q, nack_d;

    // slave drives the don't-care slot; sample it on the edge closing Q2
    always_comb begin
        nack_d = accept ? 1'b0 : (dc_bit && quar_q == 2'd2 && tick && siod) ? 1'b1 : nack_q;
    end

    always_ff @(posedge clk) begin
        if (rst) nack_q <= 1'b0;
        else     nack_q <= nack_d;
    end

    assign nack = nack_q;
`else
    assign nack = 1'b0;
`endif
endmodule
